// File: rtl/nvram_ioctl_server.sv
// nvram_ioctl_server
//
// Host-side responder for the ioctl side channel on a single ioctl index.
// Upload transfers read bytes out of a fixed-latency byte RAM. Download
// transfers write bytes into it. While a transfer is active the game core
// is asked to release the RAM through core_hold/hold_ack.
//
// Ports:
//   sys_clk, reset       clock, asynchronous active-high reset
//   ioctl_upload         host read transfer active
//   ioctl_download       host write transfer active
//   ioctl_index          transfer index; only INDEX is served
//   ioctl_rd, ioctl_wr   one-cycle host strobes
//   ioctl_addr           25-bit byte address from the host
//   ioctl_dout           host write data
//   ioctl_din            read data returned to the host
//   ioctl_wait           host stalls while high
//   core_hold            request to the core to release the RAM
//   hold_ack             core has released the RAM
//   ram_addr/rd/wr/wdata RAM command port (registered)
//   ram_rdata            RAM read data, valid RAM_LAT cycles after ram_rd
//   fsm_state            debug view of the state register
//
// Host handshake: a strobe is accepted only in the cycle it is sampled.
// The host must not issue another strobe while ioctl_wait is high. The one
// exception is the first strobe seen while the core is still being held
// off: it is latched and serviced once the RAM is granted.
module nvram_ioctl_server #(
    parameter logic [7:0] INDEX   = 8'd4,
    parameter int         AW      = 11,
    parameter int         RAM_LAT = 2
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          ioctl_upload,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          core_hold,
    input  logic          hold_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    output logic          ram_wr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    output logic [2:0]    fsm_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HOLD    = 3'd1;
    localparam logic [2:0] S_READY   = 3'd2;
    localparam logic [2:0] S_READ    = 3'd3;
    localparam logic [2:0] S_WRITE   = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0]  state;
    logic [2:0]  cnt;
    logic        oor_q;
    logic        pend_valid;
    logic        pend_wr;
    logic [24:0] pend_addr;
    logic [7:0]  pend_data;

    logic        xfer;
    logic        strobe;
    logic        strobe_wr;
    logic        go;
    logic        acc_wr;
    logic        acc_oor;
    logic [24:0] acc_addr;
    logic [7:0]  acc_data;

    // Both direction flags high at once is treated as no transfer at all.
    assign xfer      = (ioctl_upload ^ ioctl_download) && (ioctl_index == INDEX);
    assign strobe_wr = ioctl_download && ioctl_wr;
    // Strobes of the wrong type for the current direction are not strobes.
    assign strobe    = (ioctl_upload && ioctl_rd) || strobe_wr;

    // Launch an access either from READY, or straight out of HOLD when the
    // grant arrives and a strobe is pending (latched or arriving right now).
    assign go = xfer && (((state == S_HOLD) && hold_ack && (pend_valid || strobe)) ||
                         ((state == S_READY) && strobe));

    assign acc_wr   = pend_valid ? pend_wr   : strobe_wr;
    assign acc_addr = pend_valid ? pend_addr : ioctl_addr;
    assign acc_data = pend_valid ? pend_data : ioctl_dout;
    assign acc_oor  = |acc_addr[24:AW];

    assign fsm_state = state;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            oor_q      <= 1'b0;
            pend_valid <= 1'b0;
            pend_wr    <= 1'b0;
            pend_addr  <= 25'd0;
            pend_data  <= 8'd0;
            ioctl_din  <= 8'd0;
            ioctl_wait <= 1'b0;
            core_hold  <= 1'b0;
            ram_addr   <= '0;
            ram_rd     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_wdata  <= 8'd0;
        end else begin
            ram_rd <= 1'b0;
            ram_wr <= 1'b0;

            case (state)
                S_IDLE: begin
                    pend_valid <= 1'b0;
                    if (xfer) begin
                        state      <= S_HOLD;
                        core_hold  <= 1'b1;
                        ioctl_wait <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!xfer) begin
                        state      <= S_RELEASE;
                        ioctl_wait <= 1'b0;
                    end else if (hold_ack) begin
                        state      <= S_READY;
                        ioctl_wait <= 1'b0;
                    end else if (strobe && !pend_valid) begin
                        pend_valid <= 1'b1;
                        pend_wr    <= strobe_wr;
                        pend_addr  <= ioctl_addr;
                        pend_data  <= ioctl_dout;
                    end
                end
                S_READY: begin
                    if (!xfer) begin
                        state <= S_RELEASE;
                    end
                end
                S_READ: begin
                    // Data is on ram_rdata RAM_LAT cycles after the ram_rd
                    // cycle; capture it on the edge that ends that cycle.
                    if (cnt == 3'(RAM_LAT)) begin
                        ioctl_din  <= oor_q ? 8'hFF : ram_rdata;
                        ioctl_wait <= 1'b0;
                        state      <= S_READY;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_WRITE: begin
                    ioctl_wait <= 1'b0;
                    state      <= S_READY;
                end
                S_RELEASE: begin
                    core_hold <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state      <= S_IDLE;
                    core_hold  <= 1'b0;
                    ioctl_wait <= 1'b0;
                end
            endcase

            // Access launch overrides the per-state defaults above.
            if (go) begin
                pend_valid <= 1'b0;
                ioctl_wait <= 1'b1;
                oor_q      <= acc_oor;
                ram_addr   <= acc_addr[AW-1:0];
                cnt        <= 3'd0;
                if (acc_wr) begin
                    ram_wdata <= acc_data;
                    ram_wr    <= !acc_oor;
                    state     <= S_WRITE;
                end else begin
                    ram_rd <= !acc_oor;
                    state  <= S_READ;
                end
            end
        end
    end

endmodule

// File: tb/tb_nvram_ioctl_server.sv
module tb_nvram_ioctl_server;

  localparam int LAT   = 2;
  localparam int AWB   = 11;
  localparam int DEPTH = 2048;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic           ioctl_upload = 1'b0;
  logic           ioctl_download = 1'b0;
  logic [7:0]     ioctl_index = 8'd0;
  logic           ioctl_rd = 1'b0;
  logic           ioctl_wr = 1'b0;
  logic [24:0]    ioctl_addr = 25'd0;
  logic [7:0]     ioctl_dout = 8'd0;
  logic [7:0]     ioctl_din;
  logic           ioctl_wait;
  logic           core_hold;
  logic           hold_ack = 1'b0;
  logic [AWB-1:0] ram_addr;
  logic           ram_rd;
  logic           ram_wr;
  logic [7:0]     ram_wdata;
  logic [7:0]     ram_rdata;
  logic [2:0]     fsm_state;

  nvram_ioctl_server #(.INDEX(8'd4), .AW(AWB), .RAM_LAT(LAT)) dut (
    .sys_clk(clk), .reset(reset),
    .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait), .core_hold(core_hold), .hold_ack(hold_ack),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .fsm_state(fsm_state)
  );

  // ---------------- RAM device (environment) ----------------
  logic       preload = 1'b0;
  logic [7:0] ram_mem [0:DEPTH-1];
  logic [7:0] rpipe [0:LAT-1];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
    end else if (ram_wr) begin
      ram_mem[ram_addr] <= ram_wdata;
    end
    // Poison value when not reading so mistimed captures are visible.
    rpipe[0] <= ram_rd ? ram_mem[ram_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_rdata = rpipe[LAT-1];

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [0:DEPTH-1];

  function automatic logic [7:0] ref_read(input logic [24:0] a);
    if (a < 25'(DEPTH)) return ref_mem[a];
    return 8'hFF;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];
  int rd_pulses = 0;
  int wr_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ram_rd) rd_pulses++;
    if (ram_wr) begin
      wr_pulses++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {13'd0, ram_addr, ram_wdata}, 32'hFFFF_FFFF);
      end else begin
        check("wr_addr_data", {13'd0, ram_addr, ram_wdata}, {13'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic start_xfer(input logic up);
    ioctl_index = 8'd4;
    ioctl_upload = up;
    ioctl_download = !up;
    tick();
    check("start_core_hold", core_hold, 1'b1);
    check("start_wait", ioctl_wait, 1'b1);
    tick(); tick(); tick();
    hold_ack = 1'b1;
    tick();
    check("ready_wait", ioctl_wait, 1'b0);
  endtask

  task automatic end_xfer();
    ioctl_upload = 1'b0;
    ioctl_download = 1'b0;
    tick();
    check("end_hold_still", core_hold, 1'b1);
    tick();
    check("end_hold_fall", core_hold, 1'b0);
    hold_ack = 1'b0;
  endtask

  task automatic do_read(input logic [24:0] a, input string tag);
    int n;
    int rd0;
    logic [7:0] exp;
    exp = ref_read(a);
    gap();
    rd0 = rd_pulses;
    ioctl_addr = a;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      n++;
      tick();
    end
    check({tag, "_wait"}, n, LAT + 1);
    check({tag, "_din"}, ioctl_din, exp);
    check({tag, "_rdcnt"}, rd_pulses - rd0, (a < 25'(DEPTH)) ? 1 : 0);
  endtask

  task automatic do_write(input logic [24:0] a, input logic [7:0] d, input string tag);
    int n;
    int wr0;
    gap();
    if (a < 25'(DEPTH)) begin
      exp_q.push_back({a[10:0], d});
      ref_mem[a] = d;
    end
    wr0 = wr_pulses;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      n++;
      tick();
    end
    check({tag, "_wait"}, n, 1);
    check({tag, "_wrcnt"}, wr_pulses - wr0, (a < 25'(DEPTH)) ? 1 : 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int busy;
    int low;
    int rd0;
    int n;
    int order [0:15];

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

    // Reset
    preload = 1'b1;
    tick();
    preload = 1'b0;
    check("reset_outputs", {ioctl_din, ioctl_wait, core_hold, ram_rd, ram_wr, ram_wdata, 5'd0, ram_addr}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("idle_core_hold", core_hold, 1'b0);

    // Upload 0..15 plus random addresses
    start_xfer(1'b1);
    for (int i = 0; i < 16; i++) do_read(25'(i), "rd_seq");
    for (int i = 0; i < 8; i++) do_read(25'($urandom_range(0, DEPTH - 1)), "rd_rand");
    do_read(25'h800, "rd_oor");
    do_read(25'h1FFFFFF, "rd_oor_top");
    end_xfer();

    // Download 16 random bytes at 0x7F0; hold_ack drops midway
    start_xfer(1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) hold_ack = 1'b0;
      do_write(25'h7F0 + 25'(i), 8'($urandom), "wr_blk");
      if (i == 8) check("hold_kept", core_hold, 1'b1);
    end
    do_write(25'h800, 8'($urandom), "wr_oor");
    end_xfer();

    // Read the block back in random order
    for (int i = 0; i < 16; i++) order[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j;
      int t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    start_xfer(1'b1);
    for (int i = 0; i < 16; i++) do_read(25'h7F0 + 25'(order[i]), "rd_back");
    end_xfer();

    // Strobe latched while core still holds the RAM
    ioctl_index = 8'd4;
    ioctl_upload = 1'b1;
    tick();
    check("hs_core_hold", core_hold, 1'b1);
    rd0 = rd_pulses;
    ioctl_addr = 25'h123;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    low = 0;
    for (int i = 0; i < 10; i++) begin
      if (!ioctl_wait) low++;
      tick();
    end
    check("hs_wait_held", low, 0);
    check("hs_no_early_rd", rd_pulses - rd0, 0);
    hold_ack = 1'b1;
    n = 0;
    tick();
    while (ioctl_wait && n < 20) begin
      n++;
      tick();
    end
    check("hs_wait_bound", (n < 20) ? 1 : 0, 1);
    check("hs_din", ioctl_din, ref_read(25'h123));
    check("hs_rdcnt", rd_pulses - rd0, 1);
    end_xfer();

    // Wrong index, then both flags high
    busy = 0;
    ioctl_index = 8'd5;
    ioctl_upload = 1'b1;
    hold_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ioctl_rd = (i % 3 == 0);
      tick();
      if (core_hold || ram_rd || ram_wr || ioctl_wait) busy++;
    end
    check("wrong_index_idle", busy, 0);
    busy = 0;
    ioctl_index = 8'd4;
    ioctl_download = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ioctl_rd = (i % 2 == 0);
      ioctl_wr = (i % 2 == 1);
      tick();
      if (core_hold || ram_rd || ram_wr || ioctl_wait) busy++;
    end
    check("both_flags_idle", busy, 0);
    ioctl_rd = 1'b0; ioctl_wr = 1'b0;
    ioctl_upload = 1'b0; ioctl_download = 1'b0;
    hold_ack = 1'b0;
    tick();

    // Flag dropped during READ
    start_xfer(1'b1);
    ioctl_addr = 25'h3;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    n = 0;
    while (ioctl_wait && n < 20) begin
      n++;
      tick();
    end
    check("drop_wait", n, LAT + 1);
    check("drop_din", ioctl_din, ref_read(25'h3));
    check("drop_hold_at_done", core_hold, 1'b1);
    tick();
    check("drop_hold_1", core_hold, 1'b1);
    tick();
    check("drop_hold_2", core_hold, 1'b0);
    hold_ack = 1'b0;

    // Reset asserted mid-READ
    start_xfer(1'b1);
    ioctl_addr = 25'h9;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    check("mid_read_rd", ram_rd, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_outputs", {ioctl_din, ioctl_wait, core_hold, ram_rd, ram_wr, ram_wdata, 5'd0, ram_addr}, 32'd0);
    ioctl_upload = 1'b0;
    hold_ack = 1'b0;
    busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ram_rd || ram_wr || core_hold || ioctl_wait) busy++;
    end
    check("rst_held_quiet", busy, 0);
    reset = 1'b0;
    tick(); tick();
    check("post_rst_hold", core_hold, 1'b0);
    start_xfer(1'b1);
    do_read(25'h7, "post_rst_rd");
    end_xfer();

    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nvram_ioctl_server.md
# nvram_ioctl_server

Host-side responder for the ioctl side channel. It serves save-state and NVRAM upload reads (`ioctl_upload`, `ioctl_rd` → `ioctl_din`, throttled by `ioctl_wait`) and restore downloads (`ioctl_download`, `ioctl_wr`) for one ioctl index. It reaches a fixed-latency byte-wide RAM port, and it holds the game core off that RAM for the duration of each transfer. The block sits in the `sys_clk` domain beside the ROM download path. It is the reader counterpart of the existing ioctl write loader.

## Interface
Parameters:
- `INDEX`, 8'd4: the ioctl_index value this block serves; all other indices are ignored.
- `AW`, 11: RAM address width (2^AW bytes).
- `RAM_LAT`, 2: RAM read latency in cycles, 1..7.

Ports:
- `sys_clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `ioctl_upload` in 1: host upload (read) transfer active.
- `ioctl_download` in 1: host download (write) transfer active.
- `ioctl_index` in 8: transfer index.
- `ioctl_rd` in 1: one-cycle read strobe.
- `ioctl_wr` in 1: one-cycle write strobe.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: write data.
- `ioctl_din` out 8: read data.
- `ioctl_wait` out 1: host must stall while this is high.
- `core_hold` out 1: request to the core to release the RAM.
- `hold_ack` in 1: the core has released the RAM.
- `ram_addr` out AW: RAM address.
- `ram_rd` out 1: one-cycle RAM read.
- `ram_wr` out 1: one-cycle RAM write.
- `ram_wdata` out 8: RAM write data.
- `ram_rdata` in 8: RAM read data.

## Operation
A transfer is active while (`ioctl_upload` or `ioctl_download`) is high and `ioctl_index == INDEX`. If both flags are high, the block treats it as no transfer.

State machine:
- IDLE: outputs are idle.
  - On transfer start: go to HOLD and assert `core_hold`.
- HOLD: `ioctl_wait` = 1.
  - On `hold_ack` = 1: go to READY.
  - One strobe arriving in HOLD is latched (address, data, type) and serviced on entry to READY.
  - If the transfer ends while in HOLD: go to RELEASE.
- READY: `ioctl_wait` = 0.
  - `ioctl_rd` while uploading: go to READ.
  - `ioctl_wr` while downloading: go to WRITE.
  - Strobes of the wrong type are ignored.
  - Transfer ends: go to RELEASE.
- READ: issue `ram_rd` for one cycle, count RAM_LAT+1 cycles, capture `ram_rdata` into `ioctl_din`, then return to READY.
- WRITE: drive `ram_wr`, `ram_addr` and `ram_wdata` for one cycle, then return to READY.
- RELEASE: drop `core_hold` and go to IDLE.

Addressing:
- Out of range means `ioctl_addr` ≥ 2^AW.
- An out-of-range read makes no RAM access and returns 8'hFF with the same wait timing as an in-range read.
- An out-of-range write is dropped and still takes one cycle.
- `ram_addr` = `ioctl_addr[AW-1:0]`, registered.

Boundaries and priority:
- If the transfer flag drops during READ or WRITE, the access completes before RELEASE.
- Strobes received during READ or WRITE are a host protocol violation and are ignored.
- If `hold_ack` drops after READY, the block keeps going and `core_hold` stays asserted.
- If a new transfer starts in RELEASE, it is taken from IDLE on the next cycle.

## Timing
Reset values: all outputs 0, including `ioctl_din` = 8'h00, `ioctl_wait` = 0 and `core_hold` = 0. The state machine resets to IDLE.

Read, with edge E0 sampling `ioctl_rd` in READY:
- After E0: `ram_rd` = 1 for one cycle and `ioctl_wait` = 1.
- `ram_rdata` is valid in the cycle beginning RAM_LAT edges after the `ram_rd` cycle begins.
- The data is captured at E(RAM_LAT+1).
- After that same edge: `ioctl_din` is updated and `ioctl_wait` = 0.
- `ioctl_wait` is therefore high for RAM_LAT+1 cycles (3 at the default).
- `ioctl_din` holds its value until the next read completes.

Write, with edge E0 sampling `ioctl_wr`:
- After E0: `ram_wr` = 1 for one cycle and `ioctl_wait` = 1 for that one cycle.

Transfer start:
- `core_hold` rises one cycle after the start is detected.
- `ioctl_wait` rises in that same cycle.
- READY is entered on the edge after `hold_ack` is sampled high.

Transfer end:
- `core_hold` falls two cycles after the flag drop is sampled in READY (READY → RELEASE → IDLE).

Reset asserted mid-transfer: all outputs return to 0 immediately, and no RAM strobe can be emitted while reset is high.

## Test plan
- Upload, INDEX=4, RAM_LAT=2, RAM preloaded with byte[n] = n^8'h5A, `hold_ack` returned 3 cycles after `core_hold`: reads of addresses 0..15 return 5A,5B,58,…, with `ioctl_wait` high exactly 3 cycles per read and exactly one `ram_rd` per read.
- Download of 16 bytes at 0x7F0: `ram_wr` pulses 16 times with matching `ram_addr` and `ram_wdata`. A following upload reads the same bytes back.
- Read at address 0x800 with AW=11: `ioctl_din` = FF, `ram_rd` never asserted, wait is 3 cycles. A write at 0x800 produces no `ram_wr`.
- Strobe issued while in HOLD (`hold_ack` held low for 10 cycles): `ioctl_wait` stays high throughout, and the latched read is serviced once after `hold_ack` returns the correct byte.
- Wrong index (5), and both flags high: `core_hold`, `ram_rd` and `ram_wr` all stay 0.
- Flag dropped during a READ, then reset asserted mid-READ in a second run:
  - Dropped flag: the read completes, then `core_hold` falls 2 cycles later.
  - Reset: all outputs are 0 at once and the block is IDLE after reset is released.
